mc_control: RTL
===============

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have no parameters; datapath width is fixed by the 64-bit ALU, and aluControl is fixed at 4 bits.
REQ-002 SHALL provide ports, in order: clk in 1, single clock, all state updates on rising edge; reset in 1, synchronous, active-high.
REQ-003 SHALL provide opcode in 7, funct3 in 3 and funct7b5 in 1, all from the instruction register.
REQ-004 SHALL provide zero in 1, the ALU zero flag, and memReady in 1, meaning the memory access completes this cycle.
REQ-005 SHALL provide the write enables pcWrite, irWrite, regWrite and memWrite, each out 1.
REQ-006 SHALL provide adrSrc out 1, where 0 selects PC and 1 selects ALUOut as the memory address.
REQ-007 SHALL provide the mux selects aluSrcA out 2 (00 PC, 01 oldPC, 10 rs1), aluSrcB out 2 (00 rs2, 01 imm, 10 const 4) and resultSrc out 2 (00 ALUOut, 01 mem data, 10 ALU result).
REQ-008 SHALL provide aluControl out 4 (0000 AND, 0001 OR, 0010 ADD, 0110 SUB) and illegal out 1, a one-cycle pulse on an unsupported instruction.

Function
REQ-009 SHALL implement the Moore FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and JAL, with every output a function of state plus funct fields, zero and memReady only.
REQ-010 SHALL, in FETCH, drive adrSrc=0, aluSrcA=00, aluSrcB=10, ADD and resultSrc=10, and assert irWrite and pcWrite only when memReady=1; it stays in FETCH while memReady=0 and goes to DECODE otherwise.
REQ-011 SHALL, in DECODE, drive aluSrcA=01, aluSrcB=01 and ADD to form the branch target, with no write enables asserted.
REQ-012 SHALL, in DECODE, branch on opcode: 0000011/0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BEQ, 1101111 to JAL, and any other opcode to FETCH with illegal=1.
REQ-013 SHALL, in MEMADR, drive aluSrcA=10, aluSrcB=01 and ADD, then go to MEMREAD if opcode[5]=0 and to MEMWRITE otherwise.
REQ-014 SHALL, in MEMREAD, drive adrSrc=1 and hold until memReady, then go to MEMWB; MEMWB drives resultSrc=01 and regWrite=1, then goes to FETCH.
REQ-015 SHALL, in MEMWRITE, drive adrSrc=1 and memWrite=1, hold until memReady, then go to FETCH; memWrite stays high for the whole wait.
REQ-016 SHALL, in EXECR (aluSrcB=00) and EXECI (aluSrcB=01), drive aluSrcA=10 and select the ALU op from funct3: 000 gives SUB if EXECR and funct7b5=1, else ADD; 110 gives OR; 111 gives AND.
REQ-017 SHALL, in EXECR and EXECI for any other funct3, drive ADD, pulse illegal, suppress ALUWB and go to FETCH; on legal funct3 both states go to ALUWB.
REQ-018 SHALL, in ALUWB, drive resultSrc=00 and regWrite=1, then go to FETCH.
REQ-019 SHALL, in BEQ, drive aluSrcA=10, aluSrcB=00, SUB, resultSrc=00 and pcWrite=zero, then go to FETCH; funct3 other than 000 pulses illegal with pcWrite=0.
REQ-020 SHALL, in JAL, drive aluSrcA=01, aluSrcB=10, ADD, resultSrc=00 and pcWrite=1, then go to ALUWB.
REQ-021 SHALL drive all non-listed outputs to 0 in every state, including the selects.

Reset
REQ-022 SHALL, when reset=1 at a clock edge, enter FETCH regardless of the current state, including mid-wait in MEMREAD or MEMWRITE.
REQ-023 SHALL force pcWrite, irWrite, regWrite, memWrite and illegal to 0 in any cycle where reset=1, even though the state is FETCH.
REQ-024 SHALL fetch normally in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place the state enum, the opcode constants, the aluControl encodings and the mux-select encodings in shared package riscv_pkg; the ALU consumes the same aluControl constants.
REQ-026 SHALL instantiate one sub-module, alu_decoder, which maps aluOp (00 add, 01 sub, 10 funct), funct3, funct7b5 and opb5 to aluControl and an illegal bit; the FSM drives aluOp.

Verification
REQ-027 SHALL cover, with memReady tied 1, an R-type add (0110011/000/0): the sequence FETCH, DECODE, EXECR (aluControl=0010), ALUWB with regWrite=1, then FETCH, taking 4 cycles.
REQ-028 SHALL cover an R-type sub (funct7b5=1): aluControl=0110 in EXECR; the and/or variants give 0000/0001.
REQ-029 SHALL cover an ld with memReady low for 3 cycles in MEMREAD: adrSrc=1 held for 4 cycles, then MEMWB with resultSrc=01 and regWrite=1.
REQ-030 SHALL cover beq with zero=1 giving pcWrite=1 in the BEQ cycle, and with zero=0 giving pcWrite=0; both return to FETCH.
REQ-031 SHALL cover opcode 1110011: DECODE gives illegal=1 for one cycle, the next state is FETCH, and no write enable is asserted.
REQ-032 SHALL cover reset asserted during MEMWRITE wait: memWrite=0 in that cycle, and the next state is FETCH.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// ALU control codes, ALU op classes and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's op class plus funct fields to an
// aluControl code, flagging funct3 values this core does not implement.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [3:0] aluControl,
  output logic       illegal
);

  always_comb begin
    aluControl = ALU_ADD;
    illegal    = 1'b0;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means subtract for register-register ops
          F3_ADDSUB: aluControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_OR:     aluControl = ALU_OR;
          F3_AND:    aluControl = ALU_AND;
          default:   illegal    = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle RISC-V control FSM: one state per cycle, memory states wait on memReady.
// Outputs are combinational from state/funct/zero/memReady; reset masks all write enables.
module mc_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       adrSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [3:0] aluControl,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       alu_en;
  logic       opb5;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       pc_we, ir_we, reg_we, mem_we, ill_raw;

  alu_decoder u_alu_decoder (
    .aluOp      (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opb5       (opb5),
    .aluControl (dec_ctrl),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    ill_raw   = 1'b0;
    adrSrc    = 1'b0;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    resultSrc = RES_ALUOUT;
    alu_op    = ALUOP_ADD;
    alu_en    = 1'b0;
    opb5      = 1'b0;
    case (state_q)
      S_FETCH: begin
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        alu_en    = 1'b1;
        pc_we     = memReady;
        ir_we     = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        alu_en  = 1'b1;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            ill_raw = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        alu_en  = 1'b1;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = RES_MEM;
        reg_we    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1;
        mem_we = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        opb5    = (state_q == S_EXECR);
        alu_en  = 1'b1;
        // unsupported funct3 skips the writeback entirely
        ill_raw = dec_illegal;
        state_d = dec_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        alu_en  = 1'b1;
        if (funct3 == F3_ADDSUB) pc_we = zero;
        else                     ill_raw = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        alu_en  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State reads FETCH during reset, but nothing may be committed in that cycle
  assign pcWrite    = pc_we  & ~reset;
  assign irWrite    = ir_we  & ~reset;
  assign regWrite   = reg_we & ~reset;
  assign memWrite   = mem_we & ~reset;
  assign illegal    = ill_raw & ~reset;
  assign aluControl = alu_en ? dec_ctrl : 4'b0000;

endmodule
